// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: command-byte request/response bundle between a host-side
// controller and the PS/2 host-to-device transmitter.
//
// Handshake: a byte is transferred on a clk edge where tx_valid && tx_ready.
// tx_ready is high only while the transmitter is idle. tx_valid/tx_data
// presented while tx_ready is low are ignored (not queued). tx_done and
// tx_error are mutually exclusive one-cycle completion pulses, raised in
// the same cycle that tx_ready returns high.
//
// Signals:
//   tx_valid  master->slave  command byte request
//   tx_data   master->slave  command byte (8 bits)
//   tx_ready  slave->master  transmitter idle, can accept
//   tx_done   slave->master  pulse: device acknowledged the byte
//   tx_error  slave->master  pulse: no ack or device clock timeout
interface ps2_host_tx_if;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       tx_done;
  logic       tx_error;

  modport master (
    output tx_valid,
    output tx_data,
    input  tx_ready,
    input  tx_done,
    input  tx_error
  );

  modport slave (
    input  tx_valid,
    input  tx_data,
    output tx_ready,
    output tx_done,
    output tx_error
  );
endinterface

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device transmitter. Sends one command byte to
// the attached device (e.g. 0xF4 enable reporting, 0xFF reset) over the
// shared ps2_clk/ps2_data pins, then releases both lines so the packet
// receiver can resume.
//
// Ports:
//   clk, rst      system clock, asynchronous active-high reset
//   tx            ps2_host_tx_if.slave: tx_valid/tx_data/tx_ready/
//                 tx_done/tx_error
//   busy          high in every state except IDLE (= ~tx_ready)
//   ps2_clk       raw clock pin (asynchronous)
//   ps2_data      raw data pin (asynchronous)
//   ps2_clk_oe    1 = pull ps2_clk low (open drain)
//   ps2_data_oe   1 = pull ps2_data low (open drain)
//   state_dbg     current FSM state encoding
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int RTS_CYCLES     = 2000,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic          clk,
  input  logic          rst,
  ps2_host_tx_if.slave  tx,
  output logic          busy,
  input  logic          ps2_clk,
  input  logic          ps2_data,
  output logic          ps2_clk_oe,
  output logic          ps2_data_oe,
  output logic [2:0]    state_dbg
);

  localparam int IW = $clog2(INHIBIT_CYCLES);
  localparam int RW = $clog2(RTS_CYCLES);
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_INHIBIT   = 3'd1,
    S_RTS       = 3'd2,
    S_SEND      = 3'd3,
    S_WAIT_ACK  = 3'd4,
    S_WAIT_IDLE = 3'd5
  } state_t;

  state_t        state;
  logic [IW-1:0] inh_cnt;
  logic [RW-1:0] rts_cnt;
  logic [TW-1:0] to_cnt;
  logic [3:0]    bit_cnt;
  logic [7:0]    shift;
  logic          parity;
  logic          ready_r;
  logic          done_r;
  logic          error_r;
  logic          clk_oe_r;
  logic          data_oe_r;

  // Two-flop synchronizers; reset to 1 because an idle bus is pulled high,
  // so no spurious falling edge appears right after reset.
  logic clk_s1, clk_s2, clk_prev;
  logic data_s1, data_s2;
  logic fe;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      data_s1  <= 1'b1;
      data_s2  <= 1'b1;
    end else begin
      clk_s1   <= ps2_clk;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      data_s1  <= ps2_data;
      data_s2  <= data_s1;
    end
  end

  assign fe = clk_prev & ~clk_s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      inh_cnt   <= '0;
      rts_cnt   <= '0;
      to_cnt    <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      parity    <= 1'b0;
      ready_r   <= 1'b1;
      done_r    <= 1'b0;
      error_r   <= 1'b0;
      clk_oe_r  <= 1'b0;
      data_oe_r <= 1'b0;
    end else begin
      done_r  <= 1'b0;
      error_r <= 1'b0;
      case (state)
        S_IDLE: begin
          clk_oe_r  <= 1'b0;
          data_oe_r <= 1'b0;
          if (tx.tx_valid) begin
            shift    <= tx.tx_data;
            parity   <= ~^tx.tx_data;
            inh_cnt  <= '0;
            clk_oe_r <= 1'b1;
            ready_r  <= 1'b0;
            state    <= S_INHIBIT;
          end
        end
        S_INHIBIT: begin
          if (inh_cnt == IW'(INHIBIT_CYCLES - 1)) begin
            rts_cnt   <= '0;
            data_oe_r <= 1'b1;  // start bit while clock still held low
            state     <= S_RTS;
          end else begin
            inh_cnt <= inh_cnt + 1'b1;
          end
        end
        S_RTS: begin
          if (rts_cnt == RW'(RTS_CYCLES - 1)) begin
            clk_oe_r <= 1'b0;  // hand the clock to the device
            bit_cnt  <= '0;
            to_cnt   <= '0;
            state    <= S_SEND;
          end else begin
            rts_cnt <= rts_cnt + 1'b1;
          end
        end
        S_SEND, S_WAIT_ACK, S_WAIT_IDLE: begin
          if (fe) begin
            to_cnt <= '0;
            if (state == S_SEND) begin
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt < 4'd8) begin
                data_oe_r <= ~shift[bit_cnt[2:0]];
              end else if (bit_cnt == 4'd8) begin
                data_oe_r <= ~parity;
              end else begin
                data_oe_r <= 1'b0;  // stop bit: release the line
                state     <= S_WAIT_ACK;
              end
            end else if (state == S_WAIT_ACK) begin
              if (!data_s2) begin
                state <= S_WAIT_IDLE;
              end else begin
                error_r <= 1'b1;
                ready_r <= 1'b1;
                state   <= S_IDLE;
              end
            end
          end else if (state == S_WAIT_IDLE && clk_s2 && data_s2) begin
            done_r  <= 1'b1;
            ready_r <= 1'b1;
            state   <= S_IDLE;
          end else if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            clk_oe_r  <= 1'b0;
            data_oe_r <= 1'b0;
            error_r   <= 1'b1;
            ready_r   <= 1'b1;
            state     <= S_IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        default: begin
          clk_oe_r  <= 1'b0;
          data_oe_r <= 1'b0;
          ready_r   <= 1'b1;
          state     <= S_IDLE;
        end
      endcase
    end
  end

  assign tx.tx_ready = ready_r;
  assign tx.tx_done  = done_r;
  assign tx.tx_error = error_r;
  assign busy        = ~ready_r;
  assign ps2_clk_oe  = clk_oe_r;
  assign ps2_data_oe = data_oe_r;
  assign state_dbg   = state;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench for ps2_host_tx with a small PS/2 device
// model (open-drain bus, 40-cycle device clock period).
module tb_ps2_host_tx;

  logic       clk;
  logic       rst;
  logic       busy;
  logic       ps2_clk;
  logic       ps2_data;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic [2:0] state_dbg;
  logic       dev_clk;
  logic       dev_data;

  int n_cmp;
  int n_err;
  int done_seen;
  int err_seen;
  int both_seen;

  ps2_host_tx_if tx();

  ps2_host_tx #(
    .INHIBIT_CYCLES(20),
    .RTS_CYCLES(5),
    .TIMEOUT_CYCLES(200)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tx(tx),
    .busy(busy),
    .ps2_clk(ps2_clk),
    .ps2_data(ps2_data),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .state_dbg(state_dbg)
  );

  // Open-drain bus: either side may pull a line low.
  assign ps2_clk  = dev_clk & ~ps2_clk_oe;
  assign ps2_data = dev_data & ~ps2_data_oe;

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse tally over the whole run
  initial begin
    done_seen = 0;
    err_seen  = 0;
    both_seen = 0;
  end
  always @(posedge clk) begin
    if (tx.tx_done) done_seen++;
    if (tx.tx_error) err_seen++;
    if (tx.tx_done && tx.tx_error) both_seen++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver: present a byte for one accepting edge.
  task automatic start_tx(input logic [7:0] b);
    tx.tx_valid = 1'b1;
    tx.tx_data  = b;
    tick();
    tx.tx_valid = 1'b0;
  endtask

  // Count cycles clk_oe (and data_oe within it) stay high.
  task automatic measure_inhibit(output int n_clk, output int n_data);
    n_clk  = 0;
    n_data = 0;
    while (ps2_clk_oe && n_clk < 100) begin
      n_clk++;
      if (ps2_data_oe) n_data++;
      tick();
    end
  endtask

  // Device: clocks 10 bits (sampled on rising edges), then the ack clock.
  task automatic dev_run(input bit ack, output logic [9:0] bits, output int got);
    int n;
    bits = '0;
    repeat (4) tick();
    for (int i = 0; i < 10; i++) begin
      dev_clk = 1'b0;
      repeat (20) tick();
      dev_clk = 1'b1;
      bits[i] = ps2_data;
      repeat (20) tick();
    end
    dev_data = ack ? 1'b0 : 1'b1;
    dev_clk  = 1'b0;
    repeat (20) tick();
    dev_clk = 1'b1;
    repeat (5) tick();
    dev_data = 1'b1;
    got = 0;
    if (ack) begin
      n = 0;
      while (!tx.tx_done && !tx.tx_error && n < 100) begin
        tick();
        n++;
      end
      got = tx.tx_done ? 1 : 0;
    end
  endtask

  initial begin
    int nc, nd, got, d0, e0, n;
    logic [9:0] bits;
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    tx.tx_valid = 1'b0;
    tx.tx_data  = 8'h00;
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    repeat (3) tick();

    // Reset state
    check("rst_ready", tx.tx_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", tx.tx_done, 0);
    check("rst_error", tx.tx_error, 0);
    check("rst_clk_oe", ps2_clk_oe, 0);
    check("rst_data_oe", ps2_data_oe, 0);
    check("rst_state", state_dbg, 0);
    rst = 1'b0;
    tick();

    // 0xF4 with ack
    d0 = done_seen; e0 = err_seen;
    start_tx(8'hF4);
    check("f4_busy", busy, 1);
    measure_inhibit(nc, nd);
    check("f4_clk_oe_cycles", nc, 25);
    check("f4_data_oe_cycles", nd, 5);
    dev_run(1'b1, bits, got);
    check("f4_done_seen", got, 1);
    check("f4_bits", bits, 10'h2F4);
    check("f4_ready_at_done", tx.tx_ready, 1);
    repeat (5) tick();
    check("f4_done_count", done_seen - d0, 1);
    check("f4_error_count", err_seen - e0, 0);

    // 0xFF with ack
    d0 = done_seen; e0 = err_seen;
    start_tx(8'hFF);
    measure_inhibit(nc, nd);
    check("ff_clk_oe_cycles", nc, 25);
    dev_run(1'b1, bits, got);
    check("ff_done_seen", got, 1);
    check("ff_bits", bits, 10'h3FF);
    repeat (5) tick();
    check("ff_done_count", done_seen - d0, 1);
    check("ff_error_count", err_seen - e0, 0);

    // No ack: data left high on the 11th falling edge
    d0 = done_seen; e0 = err_seen;
    start_tx(8'hF4);
    measure_inhibit(nc, nd);
    dev_run(1'b0, bits, got);
    repeat (5) tick();
    check("nack_error_count", err_seen - e0, 1);
    check("nack_done_count", done_seen - d0, 0);
    check("nack_clk_oe", ps2_clk_oe, 0);
    check("nack_data_oe", ps2_data_oe, 0);
    check("nack_ready", tx.tx_ready, 1);
    check("nack_state", state_dbg, 0);

    // Device never clocks: timeout 200 cycles after clk_oe falls
    d0 = done_seen;
    start_tx(8'hF4);
    measure_inhibit(nc, nd);
    check("to_clk_oe_cycles", nc, 25);
    check("to_data_oe_held", ps2_data_oe, 1);
    n = 0;
    while (!tx.tx_error && n < 300) begin
      tick();
      n++;
    end
    check("to_latency", n, 200);
    check("to_clk_oe", ps2_clk_oe, 0);
    check("to_data_oe", ps2_data_oe, 0);
    check("to_ready", tx.tx_ready, 1);
    tick();
    check("to_error_one_cycle", tx.tx_error, 0);
    check("to_done_count", done_seen - d0, 0);

    // tx_valid held: 0xAA only accepted after 0xF4 completes
    d0 = done_seen; e0 = err_seen;
    tx.tx_valid = 1'b1;
    tx.tx_data  = 8'hF4;
    tick();
    tx.tx_data = 8'hAA;
    measure_inhibit(nc, nd);
    check("hold_clk_oe_cycles", nc, 25);
    dev_run(1'b1, bits, got);
    check("hold_first_done", got, 1);
    check("hold_first_bits", bits, 10'h2F4);
    check("hold_ready_returns", tx.tx_ready, 1);
    tick();
    check("hold_second_accept", ps2_clk_oe, 1);
    check("hold_second_ready", tx.tx_ready, 0);
    tx.tx_valid = 1'b0;
    measure_inhibit(nc, nd);
    check("hold_second_clk_oe_cycles", nc, 25);
    dev_run(1'b1, bits, got);
    check("hold_second_done", got, 1);
    check("hold_second_bits", bits, 10'h3AA);
    repeat (5) tick();
    check("hold_done_count", done_seen - d0, 2);
    check("hold_error_count", err_seen - e0, 0);

    // Reset during INHIBIT releases the clock line immediately
    d0 = done_seen; e0 = err_seen;
    start_tx(8'h12);
    repeat (3) tick();
    check("rinh_clk_oe_before", ps2_clk_oe, 1);
    rst = 1'b1;
    #1;
    check("rinh_clk_oe_async", ps2_clk_oe, 0);
    check("rinh_ready_async", tx.tx_ready, 1);
    tick();
    rst = 1'b0;
    tick();

    // Reset during SEND with bit counter at 4
    start_tx(8'hF4);
    measure_inhibit(nc, nd);
    repeat (4) tick();
    for (int i = 0; i < 4; i++) begin
      dev_clk = 1'b0;
      repeat (20) tick();
      dev_clk = 1'b1;
      repeat (20) tick();
    end
    check("rsend_state", state_dbg, 3);
    check("rsend_data_oe_before", ps2_data_oe, 1);
    rst = 1'b1;
    #1;
    check("rsend_clk_oe_async", ps2_clk_oe, 0);
    check("rsend_data_oe_async", ps2_data_oe, 0);
    tick();
    rst = 1'b0;
    repeat (3) tick();
    check("rsend_ready", tx.tx_ready, 1);
    check("rsend_busy", busy, 0);
    check("rsend_done_count", done_seen - d0, 0);
    check("rsend_error_count", err_seen - e0, 0);
    check("never_done_and_error", both_seen, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
